xfifo_axis_wr: RTL

XFIFO_AXIS_WR -- requirements
Module: xfifo_axis_wr

---
 rtl/xfifo_axis_wr.sv | 88 ++++++++
 1 files changed

// File: rtl/xfifo_axis_wr.sv
// AXI-Stream slave to FIFO write-port bridge with a two-entry skid stage.
// tready is registered; the FIFO write enable is derived from OUT validity and fifo_full.
module xfifo_axis_wr #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       aclk,
    input  logic                       rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic                       fifo_wren,
    output logic [AXIS_DATA_WIDTH-1:0] fifo_di,
    input  logic                       fifo_full,
    input  logic                       fifo_wrerr,
    output logic [COUNT_WIDTH-1:0]     beat_count,
    output logic                       wrerr_sticky
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]                 state_q;
    logic [1:0]                 state_d;
    logic                       tready_q;
    logic                       accept;
    logic                       wren;
    logic [AXIS_DATA_WIDTH-1:0] out_data_p0;
    logic [AXIS_DATA_WIDTH-1:0] skid_data_p1;
    logic [COUNT_WIDTH-1:0]     count_q;
    logic                       sticky_q;

    assign accept        = s_axis_tvalid & tready_q;
    assign wren          = (state_q != ST_EMPTY) & ~fifo_full;
    assign s_axis_tready = tready_q;
    assign fifo_wren     = wren;
    assign fifo_di       = out_data_p0;
    assign beat_count    = count_q;
    assign wrerr_sticky  = sticky_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !wren)      state_d = ST_TWO;
                else if (!accept && wren) state_d = ST_EMPTY;
            end
            ST_TWO:   if (wren) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Control: state, registered ready, write counter, sticky error.
    always_ff @(posedge aclk) begin
        if (!rst) begin
            state_q  <= ST_EMPTY;
            tready_q <= 1'b0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tready_q <= (state_d != ST_TWO);
            if (wren)       count_q  <= count_q + 1'b1;
            if (fifo_wrerr) sticky_q <= 1'b1;
        end
    end

    // Stage p0: OUT register, cleared so fifo_di reads 0 out of reset.
    always_ff @(posedge aclk) begin
        if (!rst) begin
            out_data_p0 <= '0;
        end else if ((state_q == ST_EMPTY && accept) || (state_q == ST_ONE && accept && wren)) begin
            out_data_p0 <= s_axis_tdata;
        end else if (state_q == ST_TWO && wren) begin
            out_data_p0 <= skid_data_p1;
        end
    end

    // Stage p1: SKID register, only meaningful while in ST_TWO.
    always_ff @(posedge aclk) begin
        if (state_q == ST_ONE && accept && !wren) begin
            skid_data_p1 <= s_axis_tdata;
        end
    end

endmodule
